// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_pkg
//  Purpose  : Shared types and constants for the 8-channel TDM demultiplexer.
//             Optional feature macro used by the block: TDM_DEMUX_OVERRUN_EN.
//  Revision : 1.0 - initial release
// ============================================================================
package tdm_pkg;

    // Slots per frame; the receive counter replays the 000..111 select sequence.
    localparam int NUM_CH = 8;
    localparam int SLOT_W = $clog2(NUM_CH);

    typedef logic [SLOT_W-1:0] slot_t;

    // HUNT waits for a sync-qualified beat, RECV fills the shadow frame.
    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_slot_counter
//  Purpose  : Slot index counter for the TDM demux. Load-to-1 (slot 0 has
//             just been written), increment with natural wrap 7->0, and a
//             zero flag marking the beat where slot 0 is expected.
//  Revision : 1.0 - initial release
// ============================================================================
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_load_one,
    input  logic  i_incr,
    output slot_t o_count,
    output logic  o_is_zero
);

    slot_t r_count;

    // Load has priority: a sync beat always restarts the frame at slot 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load_one) begin
            r_count <= slot_t'(1);
        end else if (i_incr) begin
            r_count <= r_count + slot_t'(1);
        end
    end

    assign o_count   = r_count;
    assign o_is_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/tdm_demux8.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux8
//  Purpose  : Eight-channel time-division demultiplexer. Collects one sample
//             per slot into a shadow frame and publishes completed frames on
//             a valid/ready port. Frames finishing while the previous one is
//             still pending are dropped.
//  Options  : TDM_DEMUX_OVERRUN_EN - adds the sticky 'overrun' output that
//             flags dropped frames (cleared only by rst_n).
//  Revision : 1.0 - initial release
// ============================================================================
module tdm_demux8 #(
    parameter int DATA_W = 1,
    parameter int NUM_CH = 8      // must stay equal to tdm_pkg::NUM_CH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_sync,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_ch,
`ifdef TDM_DEMUX_OVERRUN_EN
    output logic                     overrun,
`endif
    output logic                     sync_err
);

    import tdm_pkg::*;

    localparam slot_t c_last_slot = slot_t'(NUM_CH - 1);

    state_t r_state;
    state_t w_state_nxt;

    slot_t  w_count;
    logic   w_is_zero;
    logic   w_load_one;
    logic   w_incr;
    logic   w_wr_en;
    slot_t  w_wr_idx;
    logic   w_err;
    logic   w_complete;
    logic   w_accept;
    logic   w_take;

    logic [NUM_CH-1:0][DATA_W-1:0] r_shadow;
    logic [NUM_CH-1:0][DATA_W-1:0] w_frame;
    logic [NUM_CH*DATA_W-1:0]      r_out_ch;
    logic                          r_out_valid;
    logic                          r_sync_err;

    tdm_slot_counter u_slot_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load_one (w_load_one),
        .i_incr     (w_incr),
        .o_count    (w_count),
        .o_is_zero  (w_is_zero)
    );

    // Framing state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Per-beat framing decisions: where the sample goes, counter action, errors.
    always_comb begin
        w_state_nxt = r_state;
        w_load_one  = 1'b0;
        w_incr      = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_idx    = w_count;
        w_err       = 1'b0;
        w_complete  = 1'b0;
        if (in_valid) begin
            case (r_state)
                HUNT: begin
                    if (in_sync) begin
                        w_wr_en     = 1'b1;
                        w_wr_idx    = '0;
                        w_load_one  = 1'b1;
                        w_state_nxt = RECV;
                    end
                end
                RECV: begin
                    if (!w_is_zero && in_sync) begin
                        // Early sync: abandon the partial frame and restart.
                        w_wr_en    = 1'b1;
                        w_wr_idx   = '0;
                        w_load_one = 1'b1;
                        w_err      = 1'b1;
                    end else if (w_is_zero && !in_sync) begin
                        // Slot 0 arrived without its sync marker: lost lock.
                        w_err       = 1'b1;
                        w_state_nxt = HUNT;
                    end else begin
                        w_wr_en    = 1'b1;
                        w_incr     = 1'b1;
                        w_complete = (w_count == c_last_slot);
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    // Completed frame is the shadow with the in-flight last-slot sample merged.
    always_comb begin
        w_frame           = r_shadow;
        w_frame[NUM_CH-1] = in_data;
    end

    assign w_accept = r_out_valid & out_ready;
    assign w_take   = w_complete & (~r_out_valid | w_accept);

    // Shadow frame capture, one slot per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else if (w_wr_en) begin
            r_shadow[w_wr_idx] <= in_data;
        end
    end

    // Output frame register and valid/ready handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
        end else if (w_take) begin
            r_out_ch    <= w_frame;
            r_out_valid <= 1'b1;
        end else if (w_accept) begin
            r_out_valid <= 1'b0;
        end
    end

    // Framing error is a registered single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= w_err;
        end
    end

`ifdef TDM_DEMUX_OVERRUN_EN
    logic r_overrun;

    // Sticky flag for any completed frame that could not be published.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_complete && !w_take) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;
`endif

    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign sync_err  = r_sync_err;

endmodule
`default_nettype wire
